// File: rtl/multi_port_mem_ctrl.sv
// Round-robin arbiter that serialises 1/2/4-byte little-endian read and write
// requests from NUM_PORTS clients onto a registered byte-wide RAM/IO bus.
module multi_port_mem_ctrl #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic [7:0]                      mem_din,
    output logic [7:0]                      mem_dout,
    output logic [ADDR_WIDTH-1:0]           mem_a,
    output logic                            mem_wr,
    input  logic                            io_buffer_full,
    input  logic                            flush,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_wr,
    input  logic [2*NUM_PORTS-1:0]          req_size,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr,
    input  logic [32*NUM_PORTS-1:0]         req_wdata,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [31:0]                     resp_data
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         rr_ptr, gnt_q, gnt_idx;
    logic                  found, grant;
    logic [ADDR_WIDTH-1:0] addr_q, gnt_addr;
    logic [31:0]           wdata_q, rdata_q, gnt_wdata;
    logic [1:0]            last_q, iss, cap;
    logic                  ivld, pend, io_q, wr_q;
    logic                  io_block, rd_done;

    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] k,
                                               input logic [7:0] b);
        logic [31:0] w;
        w = word;
        w[{k, 3'b000} +: 8] = b;
        return w;
    endfunction

    assign io_block  = io_q && io_buffer_full;
    assign rd_done   = pend && (cap == last_q);
    assign mem_wr    = wr_q && rdy && !io_block;
    assign gnt_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign gnt_wdata = req_wdata[gnt_idx*32 +: 32];

    always_comb begin
        found     = 1'b0;
        gnt_idx   = '0;
        grant     = 1'b0;
        state_nxt = state;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_valid[PW'((int'(rr_ptr) + i) % NUM_PORTS)]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            end
        end
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (found && !flush) begin
                        grant     = 1'b1;
                        state_nxt = req_wr[gnt_idx] ? WRITE : READ;
                    end
                end
                READ: begin
                    if (flush || rd_done) state_nxt = IDLE;
                end
                WRITE, IO_WAIT: begin
                    if (io_block)           state_nxt = IO_WAIT;
                    else if (iss == last_q) state_nxt = IDLE;
                    else                    state_nxt = WRITE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            last_q     <= '0;
            iss        <= '0;
            cap        <= '0;
            ivld       <= 1'b0;
            pend       <= 1'b0;
            io_q       <= 1'b0;
            wr_q       <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            resp_data  <= '0;
            if (!rdy) begin
                // A data cycle swallowed by the stall is refetched from the oldest uncaptured byte.
                if (state == READ) begin
                    mem_a <= addr_q + ADDR_WIDTH'(cap);
                    iss   <= cap;
                    ivld  <= 1'b1;
                    pend  <= 1'b0;
                end
            end else if (grant) begin
                gnt_q    <= gnt_idx;
                rr_ptr   <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                addr_q   <= gnt_addr;
                wdata_q  <= gnt_wdata;
                last_q   <= last_index(req_size[gnt_idx*2 +: 2]);
                mem_a    <= gnt_addr;
                iss      <= '0;
                cap      <= '0;
                pend     <= 1'b0;
                rdata_q  <= '0;
                if (req_wr[gnt_idx]) begin
                    wr_q     <= 1'b1;
                    io_q     <= (gnt_addr[17:16] == 2'b11);
                    mem_dout <= gnt_wdata[7:0];
                    ivld     <= 1'b0;
                end else begin
                    wr_q     <= 1'b0;
                    io_q     <= 1'b0;
                    mem_dout <= '0;
                    ivld     <= 1'b1;
                end
            end else begin
                case (state)
                    READ: begin
                        if (flush) begin
                            mem_a <= '0;
                            ivld  <= 1'b0;
                            pend  <= 1'b0;
                        end else begin
                            if (pend) begin
                                rdata_q <= merge_byte(rdata_q, cap, mem_din);
                                cap     <= cap + 2'd1;
                                if (cap == last_q) begin
                                    resp_valid[gnt_q] <= 1'b1;
                                    resp_data         <= merge_byte(rdata_q, cap, mem_din);
                                end
                            end
                            pend <= ivld;
                            if (ivld && iss != last_q) begin
                                iss   <= iss + 2'd1;
                                mem_a <= addr_q + ADDR_WIDTH'(iss + 2'd1);
                            end else begin
                                mem_a <= '0;
                                ivld  <= 1'b0;
                            end
                        end
                    end
                    WRITE, IO_WAIT: begin
                        // Stores are committed, so flush never cuts a write short.
                        if (!io_block) begin
                            if (iss == last_q) begin
                                wr_q              <= 1'b0;
                                io_q              <= 1'b0;
                                mem_a             <= '0;
                                mem_dout          <= '0;
                                resp_valid[gnt_q] <= 1'b1;
                            end else begin
                                iss      <= iss + 2'd1;
                                mem_a    <= addr_q + ADDR_WIDTH'(iss + 2'd1);
                                mem_dout <= wdata_q[{iss + 2'd1, 3'b000} +: 8];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Scoreboard bench: a byte-array RAM model on the bus, a round-robin/byte-array
// reference model that predicts responses in grant order, and a separate monitor.
module tb_multi_port_mem_ctrl;
    localparam int NP = 2;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic [7:0]      mem_din = '0;
    logic [7:0]      mem_dout;
    logic [AW-1:0]   mem_a;
    logic            mem_wr;
    logic            io_buffer_full = 1'b0;
    logic            flush = 1'b0;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_wr = '0;
    logic [2*NP-1:0] req_size = '0;
    logic [AW*NP-1:0] req_addr = '0;
    logic [32*NP-1:0] req_wdata = '0;
    logic [NP-1:0]   resp_valid;
    logic [31:0]     resp_data;

    multi_port_mem_ctrl #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .flush(flush),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          ref_ptr = 0;
    logic [7:0]  ram[logic [31:0]];
    logic [7:0]  ref_mem[logic [31:0]];
    logic        t_wr[NP];
    logic [1:0]  t_size[NP];
    logic [31:0] t_addr[NP];
    logic [31:0] t_wdata[NP];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Bus-side RAM: data for the address seen in one cycle appears in the next.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic model_txn(input int p);
        int          n;
        logic [31:0] d;
        logic [31:0] a;
        exp_t        e;
        n = (t_size[p] == 2'd0) ? 1 : (t_size[p] == 2'd1) ? 2 : 4;
        d = '0;
        for (int k = 0; k < n; k++) begin
            a = t_addr[p] + 32'(k);
            if (t_wr[p]) ref_mem[a] = t_wdata[p][8*k +: 8];
            else         d[8*k +: 8] = ref_rd(a);
        end
        e.port = p;
        e.data = d;
        sbq.push_back(e);
    endtask

    // Requests raised together are served in round-robin order from ref_ptr.
    task automatic predict(input logic [NP-1:0] mask);
        logic [NP-1:0] pend;
        int            q;
        pend = mask;
        while (pend != '0) begin
            for (int i = 0; i < NP; i++) begin
                q = (ref_ptr + i) % NP;
                if (pend[q]) begin
                    model_txn(q);
                    pend[q] = 1'b0;
                    ref_ptr = (q + 1) % NP;
                    break;
                end
            end
        end
    endtask

    task automatic set_txn(input int p, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        t_wr[p] = wr; t_size[p] = size; t_addr[p] = addr; t_wdata[p] = wdata;
        req_wr[p]              = wr;
        req_size[2*p +: 2]     = size;
        req_addr[AW*p +: AW]   = addr;
        req_wdata[32*p +: 32]  = wdata;
        req_valid[p]           = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~resp_valid;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound && req_valid != '0; i++) tick();
        chk(name, 64'(req_valid), 64'd0);
        req_valid = '0;
        tick();
    endtask

    // Monitor: every response pulse must match the oldest predicted response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && resp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_port", 64'(resp_valid), 64'd1 << e.port);
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[NP];
        int s;
        logic [NP-1:0] mask;
        ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
        ref_mem[32'h1000] = 8'h78; ref_mem[32'h1001] = 8'h56;
        ref_mem[32'h1002] = 8'h34; ref_mem[32'h1003] = 8'h12;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_mem_wr", 64'(mem_wr), 0);
        chk("rst_mem_a", 64'(mem_a), 0);
        chk("rst_mem_dout", 64'(mem_dout), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_data", 64'(resp_data), 0);

        // 4-byte read, exact bus timing
        set_txn(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        predict(2'b01);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rd4_mem_a", 64'(mem_a), 64'(32'h1000 + k));
            chk("rd4_mem_wr", 64'(mem_wr), 0);
        end
        tick();
        chk("rd4_no_early_resp", 64'(resp_valid), 0);
        tick();
        chk("rd4_resp_T6", 64'(resp_valid), 64'd1);
        wait_done("rd4_done", 10);

        // Both ports stream 1-byte reads; grants must alternate
        s = ref_ptr;
        for (int k = 0; k < 8; k++) begin
            t_wr[(s + k) % NP] = 1'b0; t_size[(s + k) % NP] = 2'd0;
            t_addr[(s + k) % NP] = 32'h100 + 32'(16 * (k / 2)) + 32'((s + k) % NP);
            model_txn((s + k) % NP);
        end
        for (int p = 0; p < NP; p++) begin
            set_txn(p, 1'b0, 2'd0, 32'h100 + 32'(p), 32'h0);
            cnt[p] = 1;
        end
        for (int i = 0; i < 100 && !(cnt[0] == 4 && cnt[1] == 4 && req_valid == '0); i++) begin
            tick();
            for (int p = 0; p < NP; p++) begin
                if (!req_valid[p] && cnt[p] < 4) begin
                    set_txn(p, 1'b0, 2'd0, 32'h100 + 32'(16 * cnt[p] + p), 32'h0);
                    cnt[p]++;
                end
            end
        end
        wait_done("rr_done", 20);

        // 2-byte write from port 1
        set_txn(1, 1'b1, 2'd1, 32'h2002, 32'h0000BEEF);
        predict(2'b10);
        tick();
        chk("wr2_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2002, 8'hEF});
        tick();
        chk("wr2_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2003, 8'hBE});
        tick();
        chk("wr2_resp_T3", 64'(resp_valid), 64'd2);
        wait_done("wr2_done", 10);

        // IO write held off by a full UART buffer
        set_txn(1, 1'b1, 2'd0, 32'h30000, 32'h41);
        io_buffer_full = 1'b1;
        predict(2'b10);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("io_stall_mem_wr", 64'(mem_wr), 0);
        end
        tick();
        io_buffer_full = 1'b0;
        #1;
        chk("io_emit", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h41});
        tick();
        chk("io_resp", 64'(resp_valid), 64'd2);
        wait_done("io_done", 10);

        // Flushed read; queued port 1 served afterwards
        set_txn(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        ref_ptr = 1;
        tick();
        set_txn(1, 1'b0, 2'd0, 32'h2002, 32'h0);
        tick();
        tick();
        flush = 1'b1;
        req_valid[0] = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_bus_idle", {mem_wr, mem_a}, 0);
        chk("flush_no_resp", 64'(resp_valid), 0);
        predict(2'b10);
        tick();
        chk("flush_next_grant", 64'(mem_a), 64'h2002);
        wait_done("flush_done", 10);

        // rdy stall during byte 1's data cycle
        set_txn(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        predict(2'b01);
        tick();
        chk("rdy_T1", 64'(mem_a), 64'h1000);
        tick();
        chk("rdy_T2", 64'(mem_a), 64'h1001);
        tick();
        rdy = 1'b0;
        #1;
        chk("rdy_low_mem_wr", 64'(mem_wr), 0);
        tick();
        rdy = 1'b1;
        chk("rdy_reissue", 64'(mem_a), 64'h1001);
        wait_done("rdy_done", 12);

        // Reset in the middle of a write
        set_txn(0, 1'b1, 2'd2, 32'h5000, 32'hCAFEF00D);
        tick();
        chk("rstmid_wr_active", 64'(mem_wr), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = '0;
        ref_ptr = 0;
        chk("rstmid_idle", {mem_wr, mem_a, resp_valid}, 0);
        tick();
        chk("rstmid_no_resp", 64'(resp_valid), 0);

        // Randomised phases of simultaneous mixed requests
        for (int ph = 0; ph < 30; ph++) begin
            mask = NP'($urandom_range(1, 3));
            for (int p = 0; p < NP; p++) begin
                if (mask[p])
                    set_txn(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            32'h4000 + 32'($urandom_range(0, 60)), $urandom);
            end
            predict(mask);
            wait_done("rand_done", 40);
        end

        repeat (4) tick();
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
